// File: rtl/bcd_pkg.sv
// Shared constants, digit type and digit-count helper for the double-dabble binary-to-BCD converter.
// No logic and no latency of its own; it has no flow control.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [3:0] ADD3_THRESH = 4'd5;
  localparam logic [3:0] ADD3_VAL = 4'd3;

  typedef logic [3:0] bcd_digit_t;

  // Returns ceil(bin_w*log10(2)) decimal digits; log10(2) is approximated as 0.30103.
  function automatic int full_digits(input int bin_w);
    return (bin_w * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/binary2bcd_dd_core.sv
// Combinational double-dabble core that returns every decimal digit the input width can need.
// Zero latency, purely combinational; it has no flow control.
module binary2bcd_dd_core
  import bcd_pkg::*;
#(
  parameter int BIN_W = 8,
  parameter int FULL_DIGITS = full_digits(BIN_W)
) (
  input  logic [BIN_W-1:0]               bin,
  output logic [DIGIT_W*FULL_DIGITS-1:0] bcd
);

  logic [DIGIT_W*FULL_DIGITS-1:0] scratch;

  always_comb begin
    scratch = '0;
    for (int i = BIN_W - 1; i >= 0; i--) begin
      // A digit of 5..9 becomes 8..12, so the next shift carries a decimal overflow into the next digit.
      for (int d = 0; d < FULL_DIGITS; d++) begin
        if (scratch[DIGIT_W*d +: DIGIT_W] >= ADD3_THRESH)
          scratch[DIGIT_W*d +: DIGIT_W] = scratch[DIGIT_W*d +: DIGIT_W] + ADD3_VAL;
      end
      scratch = {scratch[DIGIT_W*FULL_DIGITS-2:0], bin[i]};
    end
    bcd = scratch;
  end

endmodule

// File: rtl/binary2bcd_double_dabble.sv
// Binary-to-BCD converter with registered packed and unpacked outputs; BCD_SATURATE_EN clamps out-of-range inputs to all 9s.
// Latency is 1 clk and it accepts one value every cycle; there is no handshake and no backpressure.
module binary2bcd_double_dabble
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BIN_W-1:0]    in_binary,
  output logic [8*DIGITS-1:0] unpacked_bcd,
  output logic [4*DIGITS-1:0] packed_bcd
);

  localparam int FULL  = full_digits(BIN_W);
  localparam int EXT_W = DIGIT_W * (FULL + DIGITS);

  logic [DIGIT_W*FULL-1:0]   full_bcd;
  logic [EXT_W-1:0]          ext_bcd;
  logic [DIGIT_W*DIGITS-1:0] packed_nxt;
  logic [8*DIGITS-1:0]       unpacked_nxt;
  logic                      unused_hi;
`ifdef BCD_SATURATE_EN
  logic                      overflow;
`endif

  binary2bcd_dd_core #(
    .BIN_W       (BIN_W),
    .FULL_DIGITS (FULL)
  ) u_core (
    .bin (in_binary),
    .bcd (full_bcd)
  );

  // Zero-extended, so digit selection stays in range even when DIGITS exceeds FULL.
  assign ext_bcd   = EXT_W'(full_bcd);
  assign unused_hi = ^ext_bcd[EXT_W-1:DIGIT_W*DIGITS];

`ifdef BCD_SATURATE_EN
  always_comb begin
    overflow = 1'b0;
    for (int k = DIGITS; k < FULL; k++)
      overflow = overflow | (ext_bcd[DIGIT_W*k +: DIGIT_W] != '0);
  end
`endif

  always_comb begin
    bcd_digit_t digit;
    digit        = '0;
    packed_nxt   = '0;
    unpacked_nxt = '0;
    for (int k = 0; k < DIGITS; k++) begin
      digit = ext_bcd[DIGIT_W*k +: DIGIT_W];
`ifdef BCD_SATURATE_EN
      if (overflow)
        digit = 4'd9;
`endif
      packed_nxt[DIGIT_W*k +: DIGIT_W] = digit;
      unpacked_nxt[8*k +: 8]           = {4'h0, digit};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      packed_bcd   <= '0;
      unpacked_bcd <= '0;
    end else begin
      packed_bcd   <= packed_nxt;
      unpacked_bcd <= unpacked_nxt;
    end
  end

endmodule

// File: tb/tb_binary2bcd_double_dabble.sv
// Self-checking bench for binary2bcd_double_dabble at default parameters; honours BCD_SATURATE_EN.
module tb_binary2bcd_double_dabble;

  logic        clk;
  logic        rst_n;
  logic [7:0]  in_binary;
  logic [15:0] unpacked_bcd;
  logic [7:0]  packed_bcd;

  int n_checks;
  int n_fail;

  binary2bcd_double_dabble dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_binary    (in_binary),
    .unpacked_bcd (unpacked_bcd),
    .packed_bcd   (packed_bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  value;
    logic [7:0]  exp_packed;
    logic [15:0] exp_unpacked;
  } vec_t;

  // Reference: decimal digits from plain division, clamped or wrapped above 99.
  function automatic int model_tens(input int v);
`ifdef BCD_SATURATE_EN
    if (v > 99) return 9;
`endif
    return (v % 100) / 10;
  endfunction

  function automatic int model_ones(input int v);
`ifdef BCD_SATURATE_EN
    if (v > 99) return 9;
`endif
    return v % 10;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name, input int v);
    logic [7:0]  ep;
    logic [15:0] eu;
    ep = 8'(model_tens(v) * 16 + model_ones(v));
    eu = 16'(model_tens(v) * 256 + model_ones(v));
    check({name, " packed"}, {8'h00, packed_bcd}, {8'h00, ep});
    check({name, " unpacked"}, unpacked_bcd, eu);
    check({name, " upper nibbles"}, {8'h00, unpacked_bcd[15:12], unpacked_bcd[7:4]}, 16'h0000);
    check({name, " packed vs unpacked"}, {8'h00, packed_bcd}, {8'h00, unpacked_bcd[11:8], unpacked_bcd[3:0]});
  endtask

  // Drive a value, then sample shortly after the edge that captures it.
  task automatic step(input logic [7:0] v);
    in_binary = v;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[12];

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_binary = 8'd47;

    vecs[0]  = '{8'd0,   8'h00, 16'h0000};
    vecs[1]  = '{8'd9,   8'h09, 16'h0009};
    vecs[2]  = '{8'd10,  8'h10, 16'h0100};
    vecs[3]  = '{8'd99,  8'h99, 16'h0909};
    vecs[4]  = '{8'd47,  8'h47, 16'h0407};
    vecs[5]  = '{8'd88,  8'h88, 16'h0808};
    vecs[6]  = '{8'd12,  8'h12, 16'h0102};
    vecs[7]  = '{8'd5,   8'h05, 16'h0005};
`ifdef BCD_SATURATE_EN
    vecs[8]  = '{8'd255, 8'h99, 16'h0909};
    vecs[9]  = '{8'd100, 8'h99, 16'h0909};
    vecs[10] = '{8'd200, 8'h99, 16'h0909};
    vecs[11] = '{8'd199, 8'h99, 16'h0909};
`else
    vecs[8]  = '{8'd255, 8'h55, 16'h0505};
    vecs[9]  = '{8'd100, 8'h00, 16'h0000};
    vecs[10] = '{8'd200, 8'h00, 16'h0000};
    vecs[11] = '{8'd199, 8'h99, 16'h0909};
`endif

    // Held in reset across several edges with a nonzero input.
    repeat (3) @(posedge clk);
    #1;
    check("reset packed", {8'h00, packed_bcd}, 16'h0000);
    check("reset unpacked", unpacked_bcd, 16'h0000);

    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first after reset packed", {8'h00, packed_bcd}, 16'h0047);
    check("first after reset unpacked", unpacked_bcd, 16'h0407);

    // Back-to-back stream, one value per cycle.
    step(8'd47); check("seq47", {8'h00, packed_bcd}, 16'h0047); check("seq47 u", unpacked_bcd, 16'h0407);
    step(8'd88); check("seq88", {8'h00, packed_bcd}, 16'h0088); check("seq88 u", unpacked_bcd, 16'h0808);
    step(8'd12); check("seq12", {8'h00, packed_bcd}, 16'h0012); check("seq12 u", unpacked_bcd, 16'h0102);
    step(8'd5);  check("seq5",  {8'h00, packed_bcd}, 16'h0005); check("seq5 u",  unpacked_bcd, 16'h0005);

    // The output must still hold the previous result until the capturing edge.
    in_binary = 8'd63;
    #2;
    check("hold before edge", {8'h00, packed_bcd}, 16'h0005);
    @(posedge clk);
    #1;
    check("after edge", {8'h00, packed_bcd}, 16'h0063);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].value);
      check($sformatf("table %0d packed", vecs[i].value), {8'h00, packed_bcd}, {8'h00, vecs[i].exp_packed});
      check($sformatf("table %0d unpacked", vecs[i].value), unpacked_bcd, vecs[i].exp_unpacked);
    end

    for (int v = 0; v < 256; v++) begin
      step(8'(v));
      check_model($sformatf("exh %0d", v), v);
    end

    for (int i = 0; i < 200; i++) begin
      int r;
      r = int'($urandom_range(255));
      step(8'(r));
      check_model($sformatf("rand %0d", r), r);
    end

    // Reset asserted between edges must clear outputs without a clock edge.
    step(8'd77);
    check("pre-reset", {8'h00, packed_bcd}, 16'h0077);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset packed", {8'h00, packed_bcd}, 16'h0000);
    check("async reset unpacked", unpacked_bcd, 16'h0000);
    in_binary = 8'd34;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("recover packed", {8'h00, packed_bcd}, 16'h0034);
    check("recover unpacked", unpacked_bcd, 16'h0304);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
